fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter FIFO_DWTH, default 8, data width in bits; it matches the upstream FIFO's data width.
REQ-002 The block SHALL have parameter PKT_LEN, default 16, words per packet, legal range 1..65535.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, with ports:
- clk, input, 1: single clock; the FIFO read-side clock.
- rst, input, 1: synchronous, active-high reset.
REQ-004 The FIFO-side ports SHALL be:
- fifo_empty, input, 1: upstream FIFO empty flag.
- fifo_rden, output, 1: read request to the upstream FIFO.
- fifo_dout, input, FIFO_DWTH: FIFO read data.
- fifo_valid, input, 1: fifo_dout is valid this cycle; arrives exactly 1 cycle after an accepted fifo_rden.
REQ-005 The stream-side ports SHALL be:
- m_data, output, FIFO_DWTH: stream data.
- m_valid, output, 1: stream data valid.
- m_ready, input, 1: downstream ready.
- m_last, output, 1: final word of a PKT_LEN-word packet.
REQ-006 The status port SHALL be err_unexp, output, 1: sticky flag indicating fifo_valid was seen without a pending read.

Function
REQ-007 The block SHALL contain a 3-entry in-order skid buffer (occ = 0..3) and a 1-bit pending-read flag (pend).
REQ-008 The block SHALL drive fifo_rden = !fifo_empty && !rst && (occ + pend) <= 2, using registered occ and pend only, so there is no combinational path from m_ready to fifo_rden.
REQ-009 pend SHALL be set to fifo_rden every cycle (1-cycle read latency).
REQ-010 When fifo_valid=1 and pend=1, the block SHALL write fifo_dout to the buffer tail in that cycle.
REQ-011 When fifo_valid=1 and pend=0, the block SHALL discard the data and set err_unexp=1; err_unexp SHALL stay 1 until reset.
REQ-012 m_valid SHALL equal (occ != 0), and m_data SHALL be the buffer head, both registered.
REQ-013 A handshake SHALL occur when m_valid && m_ready; on a handshake the buffer head SHALL pop.
REQ-014 A push and a pop in the same cycle SHALL leave occ unchanged, and the data order SHALL be preserved.
REQ-015 The buffer SHALL never overflow: occ+pend <= 3 holds by REQ-008; a push when occ=3 SHALL be impossible.
REQ-016 With m_ready held high and the FIFO non-empty, the block SHALL sustain 1 word per clock after the initial fill.
REQ-017 Latency from the first fifo_rden to m_valid SHALL be 2 cycles (rden -> fifo_valid -> registered m_valid).
REQ-018 m_data, m_valid and m_last SHALL hold stable while m_valid && !m_ready.
REQ-019 The word counter wcnt SHALL have width clog2(PKT_LEN), with a minimum of 1 bit.
REQ-020 wcnt SHALL increment on each handshake and wrap from PKT_LEN-1 to 0.
REQ-021 m_last SHALL equal m_valid && (wcnt == PKT_LEN-1); when PKT_LEN=1, m_last SHALL equal m_valid.
REQ-022 When fifo_empty rises while pend=1, the in-flight word SHALL still be accepted, and no further rden SHALL be issued.
REQ-023 The block SHALL keep no internal state machine beyond occ/pend/wcnt/err_unexp; buffer pointers SHALL wrap modulo 3.

Reset
REQ-024 While rst=1, the block SHALL drive fifo_rden=0, m_valid=0, m_last=0 and err_unexp=0, and m_data SHALL be 0.
REQ-025 The first clock edge with rst=1 SHALL clear occ, pend, wcnt, err_unexp and the buffer pointers.
REQ-026 Reset asserted mid-packet SHALL discard buffered and in-flight data; a fifo_valid in the cycle after reset deasserts SHALL be dropped without setting err_unexp.
REQ-027 The first handshake after reset SHALL be packet word 0.

Verification
REQ-028 Streaming: PKT_LEN=4, FIFO preloaded with 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, m_last high on 0x04 and 0x08, first m_valid 2 cycles after the first rden.
REQ-029 Backpressure: m_ready=0 for 10 cycles with the FIFO non-empty -> occ settles at 3, fifo_rden=0 thereafter, m_data held at the first word, no loss or duplication after m_ready=1.
REQ-030 Alternating m_ready (1,0,1,0...) over 32 words -> output sequence equals input sequence, and occ never exceeds 3.
REQ-031 Empty mid-stream: fifo_empty rises 1 cycle after an rden -> the in-flight word is delivered and no extra rden is issued; streaming resumes when empty falls.
REQ-032 Error: inject fifo_valid=1 with pend=0 -> err_unexp=1 and stays 1 until rst; the stream is unaffected.
REQ-033 Reset mid-packet: rst at word 2 of 4 -> m_valid=0 next cycle; after release, 0xA0.. streams with m_last on the 4th word.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an upstream FIFO with 1-cycle read latency into a
// valid/ready stream. A 3-entry skid buffer absorbs in-flight reads so the
// read request never depends on m_ready. Packets of PKT_LEN words are
// delimited with m_last.
module fifo_rd_stream #(
  parameter int FIFO_DWTH = 8,
  parameter int PKT_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  input  logic [FIFO_DWTH-1:0] fifo_dout,
  input  logic                 fifo_valid,
  output logic [FIFO_DWTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 err_unexp
);

  localparam int WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(PKT_LEN - 1);

  // Control state
  logic [1:0]           r_occ;
  logic                 r_pend;
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_rd_ptr;
  logic [WCW-1:0]       r_wcnt;
  logic                 r_err;
  logic                 r_rst_d;

  // Data storage (not reset; validity is tracked by r_occ)
  logic [FIFO_DWTH-1:0] r_buf [3];

  logic [2:0]           w_fill;
  logic                 w_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_unexp;

  // Buffer pointers wrap modulo 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read request looks only at registered fill level, never at m_ready.
  assign w_fill    = {1'b0, r_occ} + {2'b00, r_pend};
  assign fifo_rden = !fifo_empty && !rst && (w_fill <= 3'd2);

  assign w_valid   = (r_occ != 2'd0) && !rst;
  assign w_push    = fifo_valid && r_pend;
  assign w_pop     = w_valid && m_ready;
  // A stray valid right after reset belongs to a read issued before reset;
  // it is dropped silently instead of being flagged.
  assign w_unexp   = fifo_valid && !r_pend && !r_rst_d;

  assign m_valid   = w_valid;
  assign m_data    = w_valid ? r_buf[r_rd_ptr] : '0;
  assign m_last    = w_valid && (r_wcnt == WC_LAST);
  assign err_unexp = r_err && !rst;

  // Occupancy, pointers, pending-read flag and error/reset tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= 2'd0;
      r_pend   <= 1'b0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_err    <= 1'b0;
      r_rst_d  <= 1'b1;
    end else begin
      r_pend  <= fifo_rden;
      r_rst_d <= 1'b0;
      if (w_unexp) begin
        r_err <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Word position within the packet, advanced per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_pop) begin
      if (r_wcnt == WC_LAST) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + WCW'(1);
      end
    end
  end

  // Skid buffer write at the tail when a requested word returns.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_buf[r_wr_ptr] <= fifo_dout;
    end
  end

endmodule
